// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//
// Sequential multi-precision adder. Accepts two WORDS*N-bit operands plus a
// carry-in over a valid/ready handshake, then adds them one N-bit word per
// cycle (least significant word first) through a single full_adder #(N),
// rippling the carry from word to word. The full-width sum and the final
// carry are offered on an output valid/ready handshake.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - operand set valid
//   in_ready   - block can accept operands (IDLE only)
//   in_a/in_b  - W-bit operands, W = N*WORDS
//   in_cin     - carry into word 0
//   out_valid  - result valid (DONE only)
//   out_ready  - consumer accepts the result
//   out_sum    - in_a + in_b + in_cin modulo 2^W
//   out_cout   - carry out of the most significant word
//   busy       - high while in RUN or DONE
// ---------------------------------------------------------------------------

// N-bit full adder: sum/cout of a + b + cin.
module full_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module multiword_add_seq #(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   in_a,
    input  logic [N*WORDS-1:0]   in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 busy
);

    localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [WORDS-1:0][N-1:0]     a_q;
    logic [WORDS-1:0][N-1:0]     b_q;
    logic [WORDS-1:0][N-1:0]     res_q;    // partial result built during RUN
    logic [WORDS-1:0][N-1:0]     res_d;
    logic [WORDS-1:0][N-1:0]     sum_q;    // presented result, loaded entering DONE
    logic                        carry_q;
    logic                        cout_q;
    logic [IDX_W-1:0]            idx_q;

    logic [N-1:0]                fa_sum;
    logic                        fa_cout;

    full_adder #(.N(N)) u_full_adder (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Partial result with the current word slotted in; on the last RUN edge
    // this is the complete sum.
    always_comb begin
        res_d        = res_q;
        res_d[idx_q] = fa_sum;
    end

    // The presented result lives in its own register so out_sum/out_cout
    // change only when entering DONE, never while a new operation runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= fa_cout;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode the state register only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

    localparam int N     = 16;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain wide unsigned addition.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    // Drives one operation from a negedge, waits (bounded) for out_valid,
    // captures the result, holds out_ready low for 'hold' cycles, then
    // completes the output handshake. lat = edges after the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, output logic [W-1:0] sum, output logic cout,
                          output int lat);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sum  = out_sum;
        cout = out_cout;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h expected 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b expected 0", out_cout); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va   [3] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF};
        logic [W-1:0] vb   [3] = '{64'd2, 64'd0, 64'h0000_0001_0000_0001};
        logic         vc   [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] esum [3] = '{64'd3, 64'd0, 64'h0001_0000_0001_0000};
        logic         ecy  [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic         c;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 0, s, c, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL directed%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (s !== esum[i]) begin errors++; $display("FAIL directed%0d_sum: got %h expected %h", i, s, esum[i]); end
            checks++; if (c !== ecy[i]) begin errors++; $display("FAIL directed%0d_cout: got %b expected %b", i, c, ecy[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic         cin, c;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 24; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            // Force some words to all-ones to exercise long carry chains.
            for (int w = 0; w < WORDS; w++) begin
                if ($urandom_range(0, 2) == 0) a[w*N +: N] = '1;
            end
            exp = model(a, b, cin);
            run_op(a, b, cin, $urandom_range(0, 3), s, c, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL random%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (s !== exp[W-1:0]) begin errors++; $display("FAIL random%0d_sum: got %h expected %h", i, s, exp[W-1:0]); end
            checks++; if (c !== exp[W]) begin errors++; $display("FAIL random%0d_cout: got %b expected %b", i, c, exp[W]); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic         c;
        int           lat;
        logic [W:0]   exp;
        logic [W-1:0] a = 64'h1234_8000_FFFF_0F0F;
        logic [W-1:0] b = 64'h0001_8000_0001_F0F1;
        run_op(64'd100, 64'd200, 1'b0, 0, s, c, lat);
        checks++; if (s !== 64'd300) begin errors++; $display("FAIL bp_prev_sum: got %h expected %h", s, 64'd300); end
        exp = model(a, b, 1'b1);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // In RUN: offer different operands, which must be ignored.
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_run_in_ready: got %b expected 0", in_ready); end
            checks++; if (out_sum !== 64'd300) begin errors++; $display("FAIL bp_run_sum_hold: got %h expected %h", out_sum, 64'd300); end
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_hold: got %b expected 1", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_done_in_ready: got %b expected 0", in_ready); end
            checks++; if (out_sum !== exp[W-1:0]) begin errors++; $display("FAIL bp_sum: got %h expected %h", out_sum, exp[W-1:0]); end
            checks++; if (out_cout !== exp[W]) begin errors++; $display("FAIL bp_cout: got %b expected %b", out_cout, exp[W]); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1 = 64'hDEAD_BEEF_0000_FFFF, b1 = 64'h2152_4111_FFFF_0001;
        logic [W-1:0] a2 = 64'hFFFF_FFFF_FFFF_FFFF, b2 = 64'h0000_0000_0000_0002;
        logic [W:0]   e1, e2;
        int           lat;
        e1 = model(a1, b1, 1'b0);
        e2 = model(a2, b2, 1'b0);
        @(negedge clk);
        in_a = a1; in_b = b1; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        // Second operand set stays offered; it is only taken after the handshake.
        in_a = a2; in_b = b2;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat1: got %0d expected 4", lat); end
        checks++; if (out_sum !== e1[W-1:0]) begin errors++; $display("FAIL b2b_sum1: got %h expected %h", out_sum, e1[W-1:0]); end
        checks++; if (out_cout !== e1[W]) begin errors++; $display("FAIL b2b_cout1: got %b expected %b", out_cout, e1[W]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat2: got %0d expected 4", lat); end
        checks++; if (out_sum !== e2[W-1:0]) begin errors++; $display("FAIL b2b_sum2: got %h expected %h", out_sum, e2[W-1:0]); end
        checks++; if (out_cout !== e2[W]) begin errors++; $display("FAIL b2b_cout2: got %b expected %b", out_cout, e2[W]); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic         c;
        int           lat;
        int           seen = 0;
        @(negedge clk);
        in_a = 64'd5; in_b = 64'd6; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);            // after E0
        in_valid = 1'b0;
        if (out_valid) seen++;
        @(negedge clk);            // after E1
        if (out_valid) seen++;
        @(negedge clk);            // after E2
        if (out_valid) seen++;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_async: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_out_valid: got %0d pulses expected 0", seen); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL rmid_sum_cleared: got %h expected 0", out_sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        run_op(64'd10, 64'd11, 1'b1, 0, s, c, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rmid_latency: got %0d expected 4", lat); end
        checks++; if (s !== 64'd22) begin errors++; $display("FAIL rmid_sum: got %h expected %h", s, 64'd22); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL rmid_cout: got %b expected 0", c); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-precision adder that sits directly upstream of the team's parameterized N-bit `full_adder`. It accepts two WORDS×N-bit operands and a carry-in over a valid/ready handshake. It then feeds the operands to one internal `full_adder #(N)` instance one N-bit word per cycle, least significant word first, chaining each carry-out into the next carry-in. The full-width sum and final carry are presented on an output valid/ready handshake.

## Interface
- `N`, default 16: word width; the width of the internal `full_adder` instance.
- `WORDS`, default 4, minimum 1: number of words per operand; total operand width is W = N*WORDS.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: operand set valid.
- `in_ready`, output, 1: block can accept operands.
- `in_a`, input, W: operand A.
- `in_b`, input, W: operand B.
- `in_cin`, input, 1: carry into word 0.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, W: `in_a + in_b + in_cin`, modulo 2^W.
- `out_cout`, output, 1: carry out of word WORDS-1.
- `busy`, output, 1: high in RUN or DONE.

## Operation
- State machine with three states:
  - IDLE: `in_ready` = 1. On `in_valid & in_ready`, register `in_a`, `in_b` and `in_cin` into the carry register, clear `idx`, and go to RUN.
  - RUN: the adder is driven with `a = A[idx*N +: N]`, `b = B[idx*N +: N]`, `cin = carry`. On each edge, `sum` is written to `result[idx*N +: N]`, `cout` is written to `carry`, and `idx` increments. On the edge where `idx == WORDS-1`, go to DONE; `idx` does not wrap.
  - DONE: `out_valid` = 1. `out_sum = result` and `out_cout = carry`, both held stable until `out_valid & out_ready`, then go to IDLE.
- `in_ready` is low in RUN and DONE. `in_valid` in those states is ignored and the inputs are not sampled.
- Captured operands are internal copies. Changing `in_a`, `in_b` or `in_cin` after acceptance has no effect on the result.
- Arithmetic is unsigned. The only overflow indication is `out_cout`; no other flag exists.
- `idx` width is `max(1, clog2(WORDS))`.
- With WORDS = 1, RUN lasts exactly one cycle.
- Reset values, asynchronous on `rst_n` low: state = IDLE, `in_ready` = 1 (once `rst_n` is high), `out_valid` = 0, `busy` = 0, `out_sum` = 0, `out_cout` = 0, `idx` = 0, carry = 0, operand registers = 0.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result. After `rst_n` is released, no `out_valid` pulse occurs.

## Timing
- Accept edge E0: the edge where `in_valid & in_ready`.
- Edges E1..E_WORDS process words 0..WORDS-1. `out_valid` rises after edge E_WORDS, so latency from acceptance to `out_valid` is WORDS cycles.
- If `out_ready` is already high when `out_valid` rises, the result transfers on the next edge, E_WORDS+1, and state returns to IDLE.
- The next accept happens no earlier than E_WORDS+2. Peak throughput is one operation per WORDS+2 cycles.
- There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`. `in_ready` and `out_valid` are decoded from the registered state only.
- `out_sum` and `out_cout` may change only on the edge entering DONE or on reset.

## Test plan
- Reset check: assert `rst_n` = 0 for 3 cycles, then release. Required: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_sum` = 0, `out_cout` = 0.
- Basic add (N=16, WORDS=4): A = 1, B = 2, cin = 0. Required: `out_valid` 4 cycles after accept, `out_sum` = 3, `out_cout` = 0.
- Full carry ripple: A = 0xFFFF_FFFF_FFFF_FFFF, B = 0, cin = 1. Required: `out_sum` = 0, `out_cout` = 1.
- Mixed words with carry: A = 0x0000_FFFF_0000_FFFF, B = 0x0000_0001_0000_0001, cin = 0. Required: `out_sum` = 0x0001_0000_0001_0000, `out_cout` = 0.
- Back-pressure and ignored input:
  - Stimulus: hold `out_ready` = 0 for 5 cycles after `out_valid` rises; during RUN, pulse `in_valid` with new operands.
  - Required: `out_sum` stable throughout, new operands ignored, `in_ready` = 0 until the cycle after the output handshake.
- Reset mid-operation: accept A = 5, B = 6, drop `rst_n` on the cycle after E2, then release it. Required: `out_valid` never asserts for that operation. A following A = 10, B = 11, cin = 1 yields `out_sum` = 22, `out_cout` = 0.
